sauria_tb_mbox: RTL

Parametrised multi-channel end-of-test mailbox with per-channel watchdog, for the SAURIA demonstrator simulation fixture. It generalises the single-core exit reporting to NumChan independent reporters: CVA6 host, SAURIA driver code and DMA tests each own one channel. It is a regbus slave on the external register port, drives done/exit/timeout status to the bench, and optionally raises interrupts into intr_ext_i.

---
 rtl/sauria_tb_mbox_pkg.sv | 36 +++
 rtl/sauria_tb_mbox_chan.sv | 116 +++++++++++
 rtl/sauria_tb_mbox.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/sauria_tb_mbox_pkg.sv
// Shared definitions for the SAURIA end-of-test mailbox.
// Holds the register map layout (channel stride, word index of each register
// inside a channel), the CTRL/EXIT bit positions and the state encodings
// used by the top-level bus FSM and the per-channel state machine.
package sauria_tb_mbox_pkg;

  // Each channel occupies a 16-byte window; the ALL register follows the last one.
  localparam int unsigned ChanStride = 16;

  // Word index (addr[3:2]) of each register inside a channel window.
  localparam logic [1:0] RegCtrl   = 2'd0;
  localparam logic [1:0] RegExit   = 2'd1;
  localparam logic [1:0] RegLimit  = 2'd2;
  localparam logic [1:0] RegCycles = 2'd3;

  // CTRL bits.
  localparam int unsigned CtrlStartBit = 0;
  localparam int unsigned CtrlClearBit = 1;
  localparam int unsigned CtrlIrqEnBit = 2;

  // EXIT bits: bit0 reports completion, [31:1] carry the exit code.
  localparam int unsigned ExitDoneBit = 0;

  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_RUN     = 2'd1,
    CH_DONE    = 2'd2,
    CH_TIMEOUT = 2'd3
  } chan_state_e;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_RESP = 1'b1
  } bus_state_e;

endpackage

// File: rtl/sauria_tb_mbox_chan.sv
// One mailbox channel: state machine, watchdog cycle counter, limit and
// exit code. Writes arrive as single-cycle strobes from the top decoder.
// Optional feature macro: SAURIA_TB_MBOX_IRQ_EN (per-channel level interrupt
// with CTRL bit2 enable); when undefined irq_o and irq_en_o are tied low.
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   ctrl_we_i/exit_we_i/
//   limit_we_i              write strobes for CTRL / EXIT / LIMIT
//   wdata_i                 write data shared by the strobes
//   state_o                 channel state (chan_state_e encoding)
//   cnt_o, limit_o, code_o  cycle counter, watchdog limit, exit code
//   irq_en_o, irq_o         interrupt enable readback, interrupt level
module sauria_tb_mbox_chan
  import sauria_tb_mbox_pkg::*;
#(
  parameter int unsigned TimeoutWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    ctrl_we_i,
  input  logic                    exit_we_i,
  input  logic                    limit_we_i,
  input  logic [31:0]             wdata_i,
  output logic [1:0]              state_o,
  output logic [TimeoutWidth-1:0] cnt_o,
  output logic [TimeoutWidth-1:0] limit_o,
  output logic [30:0]             code_o,
  output logic                    irq_en_o,
  output logic                    irq_o
);

  chan_state_e             state_q, state_d;
  logic [TimeoutWidth-1:0] cnt_q, cnt_d, limit_q;
  logic [30:0]             code_q, code_d;
  logic                    start, clear, done_wr, timeout_hit;

  assign start   = ctrl_we_i & wdata_i[CtrlStartBit];
  assign clear   = ctrl_we_i & wdata_i[CtrlClearBit];
  assign done_wr = exit_we_i & wdata_i[ExitDoneBit];
  // limit = 0 disables the watchdog; otherwise fire on the edge where the
  // counter would reach the limit, so CYCLES reads exactly the limit.
  assign timeout_hit = (limit_q != '0) && (cnt_q == limit_q - TimeoutWidth'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CH_IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      if (limit_we_i) limit_q <= wdata_i[TimeoutWidth-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    if (clear) begin
      // CLEAR together with START restarts the channel directly.
      state_d = start ? CH_RUN : CH_IDLE;
      cnt_d   = '0;
      code_d  = '0;
    end else begin
      unique case (state_q)
        CH_IDLE: begin
          if (start) begin
            state_d = CH_RUN;
            cnt_d   = '0;
          end else if (done_wr) begin
            state_d = CH_DONE;
            code_d  = wdata_i[31:1];
          end
        end
        CH_RUN: begin
          // A completion report beats a watchdog expiry on the same edge.
          if (done_wr) begin
            state_d = CH_DONE;
            code_d  = wdata_i[31:1];
          end else if (timeout_hit) begin
            state_d = CH_TIMEOUT;
            cnt_d   = limit_q;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + TimeoutWidth'(1);
          end
        end
        default: ; // DONE and TIMEOUT are sticky until CLEAR
      endcase
    end
  end

  assign state_o = state_q;
  assign cnt_o   = cnt_q;
  assign limit_o = limit_q;
  assign code_o  = code_q;

`ifdef SAURIA_TB_MBOX_IRQ_EN
  logic irq_en_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        irq_en_q <= 1'b0;
    else if (ctrl_we_i) irq_en_q <= wdata_i[CtrlIrqEnBit];
  end

  assign irq_en_o = irq_en_q;
  // Finished states are held until CLEAR, so the level follows the state.
  assign irq_o    = irq_en_q & ((state_q == CH_DONE) | (state_q == CH_TIMEOUT));
`else
  assign irq_en_o = 1'b0;
  assign irq_o    = 1'b0;
`endif

endmodule

// File: rtl/sauria_tb_mbox.sv
// Multi-channel end-of-test mailbox with per-channel watchdog for the SAURIA
// simulation fixture. Regbus slave with NumChan independent channels plus a
// read-only ALL summary register at offset 16*NumChan.
// Optional feature macro: SAURIA_TB_MBOX_IRQ_EN (per-channel interrupts).
// Bus handshake: a request is accepted on the edge where req_valid_i is high
// and the bus FSM is IDLE; the requester holds the request until it sees
// rsp_ready_o. rsp_ready_o is high for exactly the RESP cycle that follows,
// with rsp_rdata_o/rsp_error_o valid alongside; writes take effect on the
// edge ending RESP. No request is accepted during RESP.
// Ports:
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   req_valid_i/write/addr/wdata/wstrb regbus request
//   rsp_ready_o/rdata_o/error_o        regbus response (one-cycle strobe)
//   done_o, timeout_o, exit_code_o     per-channel status (31-bit codes)
//   all_done_o                         every channel DONE or TIMEOUT
//   irq_o                              per-channel interrupt
module sauria_tb_mbox
  import sauria_tb_mbox_pkg::*;
#(
  parameter int unsigned           NumChan      = 4,
  parameter int unsigned           AddrWidth    = 32,
  parameter int unsigned           TimeoutWidth = 32,
  parameter logic [AddrWidth-1:0]  BaseAddr     = AddrWidth'(32'h0300_8000)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_valid_i,
  input  logic                   req_write_i,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic [31:0]            req_wdata_i,
  input  logic [3:0]             req_wstrb_i,
  output logic                   rsp_ready_o,
  output logic [31:0]            rsp_rdata_o,
  output logic                   rsp_error_o,
  output logic [NumChan-1:0]     done_o,
  output logic [NumChan-1:0]     timeout_o,
  output logic [NumChan*31-1:0]  exit_code_o,
  output logic                   all_done_o,
  output logic [NumChan-1:0]     irq_o
);

  bus_state_e            bus_q, bus_d;
  logic                  req_write_q;
  logic [AddrWidth-1:0]  req_addr_q;
  logic [31:0]           req_wdata_q;
  logic [3:0]            req_wstrb_q;

  logic [AddrWidth-1:0]  off;
  logic [AddrWidth-5:0]  chan_sel;
  logic [1:0]            reg_sel;
  logic                  unaligned, in_chan, is_all, bad_wr, err, wr_en;
  logic [31:0]           rdata_mux;

  logic [NumChan-1:0]    chan_hit, ctrl_we, exit_we, limit_we, chan_irq_en;
  logic [1:0]            chan_state [NumChan];
  logic [TimeoutWidth-1:0] chan_cnt [NumChan];
  logic [TimeoutWidth-1:0] chan_limit [NumChan];
  logic [30:0]           chan_code [NumChan];

  // Bus FSM: state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) bus_q <= BUS_IDLE;
    else         bus_q <= bus_d;
  end

  // Bus FSM: next state.
  always_comb begin
    bus_d = bus_q;
    unique case (bus_q)
      BUS_IDLE: if (req_valid_i) bus_d = BUS_RESP;
      BUS_RESP: bus_d = BUS_IDLE;
      default:  bus_d = BUS_IDLE;
    endcase
  end

  // Request latch, loaded on acceptance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
    end else if (bus_q == BUS_IDLE && req_valid_i) begin
      req_write_q <= req_write_i;
      req_addr_q  <= req_addr_i;
      req_wdata_q <= req_wdata_i;
      req_wstrb_q <= req_wstrb_i;
    end
  end

  // Address decode on the latched request. Addresses below BaseAddr wrap to
  // a huge offset and fall out of range.
  assign off       = req_addr_q - BaseAddr;
  assign chan_sel  = off[AddrWidth-1:4];
  assign reg_sel   = off[3:2];
  assign unaligned = off[1:0] != 2'b00;
  assign in_chan   = chan_sel < (AddrWidth-4)'(NumChan);
  assign is_all    = off == AddrWidth'(ChanStride * NumChan);
  assign bad_wr    = req_write_q &
                     (is_all | (reg_sel == RegCycles) | (req_wstrb_q != 4'hF));
  assign err       = unaligned | ~(in_chan | is_all) | bad_wr;

  // Bus FSM: outputs.
  always_comb begin
    rsp_ready_o = 1'b0;
    rsp_error_o = 1'b0;
    rsp_rdata_o = '0;
    wr_en       = 1'b0;
    if (bus_q == BUS_RESP) begin
      rsp_ready_o = 1'b1;
      rsp_error_o = err;
      wr_en       = req_write_q & ~err;
      if (!err && !req_write_q) rsp_rdata_o = rdata_mux;
    end
  end

  always_comb begin
    rdata_mux = '0;
    if (is_all) begin
      rdata_mux[0]              = all_done_o;
      rdata_mux[16 +: NumChan]  = timeout_o;
    end
    for (int c = 0; c < NumChan; c++) begin
      if (chan_hit[c]) begin
        unique case (reg_sel)
          RegCtrl:  rdata_mux = {29'b0, chan_irq_en[c], chan_state[c]};
          RegExit:  rdata_mux = {chan_code[c], chan_state[c] == CH_DONE};
          RegLimit: rdata_mux = 32'(chan_limit[c]);
          default:  rdata_mux = 32'(chan_cnt[c]);
        endcase
      end
    end
  end

  for (genvar c = 0; c < NumChan; c++) begin : g_chan
    assign chan_hit[c] = in_chan && (chan_sel == (AddrWidth-4)'(c));
    assign ctrl_we[c]  = wr_en & chan_hit[c] & (reg_sel == RegCtrl);
    assign exit_we[c]  = wr_en & chan_hit[c] & (reg_sel == RegExit);
    assign limit_we[c] = wr_en & chan_hit[c] & (reg_sel == RegLimit);

    sauria_tb_mbox_chan #(
      .TimeoutWidth(TimeoutWidth)
    ) u_chan (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .ctrl_we_i (ctrl_we[c]),
      .exit_we_i (exit_we[c]),
      .limit_we_i(limit_we[c]),
      .wdata_i   (req_wdata_q),
      .state_o   (chan_state[c]),
      .cnt_o     (chan_cnt[c]),
      .limit_o   (chan_limit[c]),
      .code_o    (chan_code[c]),
      .irq_en_o  (chan_irq_en[c]),
      .irq_o     (irq_o[c])
    );

    // Status outputs decode channel registers only.
    assign done_o[c]               = chan_state[c] == CH_DONE;
    assign timeout_o[c]            = chan_state[c] == CH_TIMEOUT;
    assign exit_code_o[31*c +: 31] = chan_code[c];
  end

  assign all_done_o = &(done_o | timeout_o);

endmodule
